// File: rtl/lfsr_bist_ctrl_if.sv
// Harness/LFSR-facing signal bundle for lfsr_bist_ctrl; the controller uses the slave view,
// the test harness and LFSR model use the master view.
`timescale 1ns/1ps
interface lfsr_bist_ctrl_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [W-1:0]     seed_in;
    logic [CNT_W-1:0] exp_period;
    logic [W-1:0]     lfsr_out;
    logic             lfsr_load;
    logic [W-1:0]     lfsr_seed;
    logic             lfsr_en;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic             err_zero;
    logic [CNT_W-1:0] period;
    logic [W-1:0]     signature;

    modport slave (
        input  start, abort, seed_in, exp_period, lfsr_out,
        output lfsr_load, lfsr_seed, lfsr_en, busy, done, pass, timeout, err_zero,
               period, signature
    );

    modport master (
        output start, abort, seed_in, exp_period, lfsr_out,
        input  lfsr_load, lfsr_seed, lfsr_en, busy, done, pass, timeout, err_zero,
               period, signature
    );
endinterface

// File: rtl/lfsr_bist_ctrl.sv
// BIST sequencer for an external LFSR: seeds it, measures the seed recurrence period,
// compacts every visited state into a MISR and grades the period against an expected value.
`timescale 1ns/1ps
module lfsr_bist_ctrl #(
    parameter int             W          = 4,
    parameter int             CNT_W      = 8,
    parameter int             MAX_CYCLES = 255,
    parameter logic [W-1:0]   MISR_POLY  = 4'h9
) (
    input  logic              clk,
    input  logic              rst,
    lfsr_bist_ctrl_if.slave   bist
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [W-1:0]     seed_q;
    logic [CNT_W-1:0] exp_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     sig_q;
    logic [CNT_W-1:0] period_q;
    logic             load_q;
    logic             en_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             timeout_q;
    logic             err_q;

    logic [CNT_W-1:0] cnt_d;
    logic [W-1:0]     sig_d;

    function automatic logic [W-1:0] misr_step(input logic [W-1:0] sig, input logic [W-1:0] din);
        logic [W-1:0] fb;
        fb = sig[W-1] ? MISR_POLY : '0;
        return ({sig[W-2:0], 1'b0} ^ fb) ^ din;
    endfunction

    assign cnt_d = cnt_q + 1'b1;
    assign sig_d = misr_step(sig_q, bist.lfsr_out);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            seed_q    <= '0;
            exp_q     <= '0;
            cnt_q     <= '0;
            sig_q     <= '0;
            period_q  <= '0;
            load_q    <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (bist.abort) begin
            // Abort is a soft reset; in IDLE everything is already clear so it changes nothing.
            state_q   <= S_IDLE;
            seed_q    <= '0;
            exp_q     <= '0;
            cnt_q     <= '0;
            sig_q     <= '0;
            period_q  <= '0;
            load_q    <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bist.start) begin
                        seed_q    <= bist.seed_in;
                        exp_q     <= bist.exp_period;
                        cnt_q     <= '0;
                        sig_q     <= '0;
                        period_q  <= '0;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        if (bist.seed_in == '0) begin
                            // An all-zero seed would lock the LFSR up, so skip straight to DONE.
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            load_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            err_q   <= 1'b0;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            load_q  <= 1'b1;
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    load_q  <= 1'b0;
                    en_q    <= 1'b1;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    // cnt==0 is the cycle the seed itself is on the bus, so it cannot count as a recurrence.
                    if (cnt_q != '0 && bist.lfsr_out == seed_q) begin
                        period_q <= cnt_q;
                        en_q     <= 1'b0;
                        state_q  <= S_CHECK;
                    end else if (cnt_q == CNT_W'(MAX_CYCLES)) begin
                        period_q  <= cnt_q;
                        timeout_q <= 1'b1;
                        en_q      <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                        sig_q <= sig_d;
                    end
                end
                S_CHECK: begin
                    pass_q  <= (period_q == exp_q);
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bist.lfsr_load = load_q;
    assign bist.lfsr_seed = seed_q;
    assign bist.lfsr_en   = en_q;
    assign bist.busy      = busy_q;
    assign bist.done      = done_q;
    assign bist.pass      = pass_q;
    assign bist.timeout   = timeout_q;
    assign bist.err_zero  = err_q;
    assign bist.period    = period_q;
    assign bist.signature = sig_q;

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Directed bench for lfsr_bist_ctrl: drives a 4-bit x^4+x^3+1 LFSR model and checks the
// controller every cycle against a sequence-level model of period, MISR and timing.
`timescale 1ns/1ps
module tb_lfsr_bist_ctrl;

    localparam int W    = 4;
    localparam int CW   = 8;
    localparam int MAXC = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lfsr_bist_ctrl_if #(.W(W), .CNT_W(CW)) bif ();

    lfsr_bist_ctrl #(
        .W(W), .CNT_W(CW), .MAX_CYCLES(MAXC), .MISR_POLY(4'h9)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bist (bif)
    );

    logic [W-1:0] lfsr_q = 4'h0;
    logic         stuck  = 1'b0;

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    function automatic logic [3:0] misr(input logic [3:0] s, input logic [3:0] d);
        return ({s[2:0], 1'b0} ^ (s[3] ? 4'h9 : 4'h0)) ^ d;
    endfunction

    always @(posedge clk) begin
        if (bif.lfsr_load)    lfsr_q <= bif.lfsr_seed;
        else if (bif.lfsr_en) lfsr_q <= lfsr_next(lfsr_q);
    end
    assign bif.lfsr_out = stuck ? 4'h3 : lfsr_q;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model of one test, from the sequence of states the LFSR visits.
    logic [3:0] states [0:MAXC+1];
    logic [3:0] sigp   [0:MAXC+1];
    logic [3:0] m_seed;
    logic [7:0] m_exp;
    int         m_per;
    logic       m_to;
    logic       m_err;
    int         m_fin;

    task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s t=%0d got=%0h want=%0h", nm, t, act, req);
    endtask

    task automatic build_model(input logic [3:0] seed, input logic [7:0] expp, input logic stk);
        m_seed = seed;
        m_exp  = expp;
        m_err  = (seed == 4'h0);
        states[0] = stk ? 4'h3 : seed;
        for (int k = 1; k <= MAXC + 1; k++)
            states[k] = stk ? 4'h3 : lfsr_next(states[k-1]);
        m_per = 0;
        for (int k = 1; k <= MAXC; k++)
            if (m_per == 0 && states[k] == seed) m_per = k;
        m_to  = (m_per == 0);
        m_fin = m_to ? MAXC : m_per;
        sigp[0] = 4'h0;
        for (int k = 1; k <= MAXC + 1; k++)
            sigp[k] = misr(sigp[k-1], states[k-1]);
    endtask

    task automatic check_cleared(input string nm, input int t);
        chk(nm, t, {bif.lfsr_load, bif.lfsr_en, bif.busy, bif.done, bif.pass, bif.timeout,
                    bif.err_zero, bif.period, bif.signature, bif.lfsr_seed}, 32'h0);
    endtask

    // Expected outputs t cycles after the edge that accepted start.
    task automatic compare(input int t);
        int run_last, t_end;
        logic [3:0] ctl;
        run_last = m_to ? MAXC + 1 : m_per + 1;
        t_end    = m_to ? MAXC + 2 : m_per + 3;
        chk("seed", t, bif.lfsr_seed, m_seed);
        ctl = {bif.lfsr_load, bif.lfsr_en, bif.busy, bif.done};
        if (m_err) begin
            chk("ctl_zero", t, ctl, 4'b0001);
            chk("res_zero", t, {bif.err_zero, bif.pass, bif.timeout, bif.period, bif.signature},
                {1'b1, 1'b0, 1'b0, 8'd0, 4'h0});
        end else if (t == 0) begin
            chk("ctl_load", t, ctl, 4'b1010);
        end else if (t <= run_last) begin
            chk("ctl_run", t, ctl, 4'b0110);
            chk("sig_run", t, bif.signature, sigp[t-1]);
        end else if (t < t_end) begin
            chk("ctl_check", t, ctl, 4'b0010);
            chk("sig_check", t, bif.signature, sigp[m_fin]);
        end else begin
            chk("ctl_done", t, ctl, 4'b0001);
            chk("period", t, bif.period, m_fin);
            chk("pass", t, bif.pass, !m_to && (m_per == int'(m_exp)));
            chk("timeout", t, bif.timeout, m_to);
            chk("err_zero", t, bif.err_zero, 1'b0);
            chk("signature", t, bif.signature, sigp[m_fin]);
        end
    endtask

    task automatic run_test(input logic [3:0] seed, input logic [7:0] expp, input logic stk,
                            input int abort_at, input int rst_at);
        int t_end;
        build_model(seed, expp, stk);
        t_end = m_err ? 0 : (m_to ? MAXC + 2 : m_per + 3);
        stuck = stk;
        bif.seed_in    = seed;
        bif.exp_period = expp;
        bif.start      = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        for (int t = 0; t <= t_end + 2; t++) begin
            compare(t);
            if (t == abort_at) begin
                bif.abort = 1'b1;
                @(posedge clk); #1;
                bif.abort = 1'b0;
                check_cleared("abort_clear", t + 1);
                return;
            end
            if (t == rst_at) begin
                #2 rst = 1'b0;
                #1 check_cleared("async_rst_clear", t);
                @(posedge clk); #1;
                rst = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bif.start      = 1'b0;
        bif.abort      = 1'b0;
        bif.seed_in    = 4'h0;
        bif.exp_period = 8'd0;
        #1 check_cleared("reset_state", 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Pin the model against hand-worked values before trusting it.
        build_model(4'h8, 8'd15, 1'b0);
        chk("pin_period", 0, m_per, 15);
        chk("pin_sig5", 0, sigp[5], 4'h6);
        chk("pin_sig15", 0, sigp[15], 4'h0);
        build_model(4'h8, 8'd15, 1'b1);
        chk("pin_timeout", 0, m_to, 1'b1);

        run_test(4'h8, 8'd15, 1'b0, -1, -1);   // good period, pass
        run_test(4'h8, 8'd14, 1'b0, -1, -1);   // wrong expectation, restarted from DONE
        run_test(4'h8, 8'd15, 1'b1, -1, -1);   // stuck LFSR -> timeout
        run_test(4'h0, 8'd15, 1'b0, -1, -1);   // zero seed, no load pulse
        run_test(4'h8, 8'd15, 1'b0, 5, -1);    // abort mid-RUN

        bif.seed_in = 4'h8;
        bif.start   = 1'b1;
        bif.abort   = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        bif.abort = 1'b0;
        check_cleared("start_abort_idle", 0);
        @(posedge clk); #1;
        check_cleared("start_abort_idle_hold", 1);

        run_test(4'h8, 8'd15, 1'b0, -1, 6);    // async reset mid-RUN
        @(posedge clk); #1;
        check_cleared("after_rst_release", 0);
        run_test(4'h8, 8'd15, 1'b0, -1, -1);   // fresh run after reset

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
